a2d_chnl_arbiter: RTL and testbench
===================================

// Module: a2d_chnl_arbiter
// PURPOSE
//  Shares the single A2D converter between NUM_REQ requesters, e.g. the PSIC sequencer and a periodic PTAT monitor.
//  Arbitrates round-robin and drives the A2D strt_cnv/chnl handshake on behalf of the winner.
//  Captures the conversion result and returns it to the owner with a one-cycle done pulse.
//  Sits between the requesting controllers and the A2D interface block.
// PARAMETERS
//  NUM_REQ  2     number of requesters (2..8)
//  RES_W    12    A2D result width
//  TMO_CYC  4096  conversion timeout in clk cycles (used only with A2D_ARB_TMO_EN)
// PORTS
//  clk        in   1        system clock; all logic on rising edge
//  rst        in   1        synchronous, active-high reset
//  req        in   NUM_REQ  level request per requester; hold until done
//  req_chnl   in   NUM_REQ  channel per requester, 0=PTAT, 1=Pressure; sampled at grant
//  gnt        out  NUM_REQ  one-hot owner, high from START through DONE
//  done       out  NUM_REQ  one-cycle pulse to owner; res valid that cycle
//  err        out  NUM_REQ  one-cycle timeout pulse to owner, coincident with done
//  res        out  RES_W    last captured result, held until next capture
//  busy       out  1        high in every state except IDLE
//  strt_cnv   out  1        one-cycle A2D conversion start
//  chnl       out  1        A2D channel select; held stable START..DONE
//  cnv_cmplt  in   1        A2D conversion complete (pulse or level)
//  a2d_res    in   RES_W    A2D result; valid while cnv_cmplt=1
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE; gnt, done, err, res, busy, strt_cnv, chnl all 0; rr pointer=0 (req[0] highest priority).
//  States (one-hot): IDLE, START, CONV, DONE.
//  IDLE: if |req, pick first set bit at or after ptr (wrapping); latch owner and chnl=req_chnl[owner] -> START; else stay.
//  START: strt_cnv=1 for exactly this cycle -> CONV.
//  CONV: wait for cnv_cmplt; when sampled 1, res<=a2d_res -> DONE.
//  DONE: done[owner]=1; ptr<=owner+1 (mod NUM_REQ) -> IDLE.
//  Latency: req seen in IDLE at cycle 0 -> strt_cnv cycle 1; cnv_cmplt at cycle k -> done/res at cycle k+1.
//  Minimum round trip: 4 cycles; back-to-back grants have one IDLE cycle between them.
//  cnv_cmplt is ignored in IDLE, START and DONE.
//  Owner dropping req mid-conversion: the conversion completes and done still pulses. No abort.
//  A requester holding req after done competes again and loses to any other pending requester (fairness).
//  req/req_chnl of non-owners may change freely while busy; they are ignored until IDLE.
//  rst mid-operation: immediate return to IDLE. No done/err pulse; the in-flight A2D result is discarded.
//  gnt is one-hot or zero at all times; at most one of done bits high per cycle.
// CONFIGURATION
//  A2D_ARB_TMO_EN defined:
//   - A CONV cycle counter (cleared in START) runs while in CONV.
//   - If it reaches TMO_CYC-1 without cnv_cmplt: err[owner]=1 and done[owner]=1 in DONE, res unchanged.
//  A2D_ARB_TMO_EN undefined:
//   - No counter; CONV waits indefinitely.
//   - err tied to 0; the port is kept so instantiations are identical.
// STRUCTURE
//  Package a2d_arb_pkg:
//   - state_t one-hot enum: IDLE=4'h1, START=4'h2, CONV=4'h4, DONE=4'h8.
//   - Channel constants CHNL_PTAT=1'b0, CHNL_PRESS=1'b1.
//  Sub-module rr_priority_pick (combinational): inputs req, ptr; output one-hot pick plus encoded index.
//  The top level holds the state register, owner/ptr/chnl/res flops and the optional timeout counter.
// TESTING
//  1 Reset: rst=1 for 2 cycles, random inputs -> all outputs 0, busy=0.
//  2 Single: req=2'b01, req_chnl=2'b01 -> strt_cnv at cycle 1, chnl=1.
//    cnv_cmplt with a2d_res=12'hA5C 10 cycles later -> next cycle done=2'b01, res=12'hA5C.
//  3 Contention: req=2'b11 held from reset -> grants 0,1,0,1; each done pulses one cycle; gnt never 2'b11.
//  4 Spurious: cnv_cmplt=1 in IDLE and START -> no state advance, no done.
//    A later real cnv_cmplt in CONV completes normally.
//  5 Reset mid-CONV: rst=1 one cycle -> IDLE, gnt=0, no done.
//    With req=2'b10, next grant goes to requester 1 and ptr restarts at 0.
//  6 Timeout (A2D_ARB_TMO_EN, TMO_CYC=16): no cnv_cmplt -> err and done to owner 16 cycles after strt_cnv, res unchanged.
//    Without the macro: busy stays 1, err stays 0.

Source files
------------

// File: rtl/a2d_chnl_arbiter_pkg.sv
// Shared types for the A2D channel arbiter: one-hot FSM state encoding and channel-select constants.
package a2d_arb_pkg;

   typedef enum logic [3:0] {
      IDLE  = 4'h1,
      START = 4'h2,
      CONV  = 4'h4,
      DONE  = 4'h8
   } state_t;

   localparam logic CHNL_PTAT  = 1'b0;
   localparam logic CHNL_PRESS = 1'b1;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping around.
// Returns the winner both one-hot and as an encoded index; pick_o is zero when nothing is requested.
module rr_priority_pick #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] pick_o,
   output logic [IDX_W-1:0]   idx_o
);

   logic [IDX_W:0] slot;
   logic           found;

   // Walk the requesters starting at the pointer; the first hit wins.
   always_comb begin
      pick_o = '0;
      idx_o  = '0;
      found  = 1'b0;
      slot   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         slot = {1'b0, ptr_i} + (IDX_W+1)'(i);
         if (slot >= (IDX_W+1)'(NUM_REQ)) begin
            slot = slot - (IDX_W+1)'(NUM_REQ);
         end
         if (!found && req_i[slot[IDX_W-1:0]]) begin
            found                     = 1'b1;
            pick_o[slot[IDX_W-1:0]]   = 1'b1;
            idx_o                     = slot[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/a2d_chnl_arbiter.sv
// Round-robin arbiter sharing one A2D converter between NUM_REQ requesters.
// Optional conversion timeout enabled by defining A2D_ARB_TMO_EN.
module a2d_chnl_arbiter
   import a2d_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int RES_W   = 12,
   parameter int TMO_CYC = 4096
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [NUM_REQ-1:0] req_chnl_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [NUM_REQ-1:0] done_o,
   output logic [NUM_REQ-1:0] err_o,
   output logic [RES_W-1:0]   res_o,
   output logic               busy_o,
   output logic               strt_cnv_o,
   output logic               chnl_o,
   input  logic               cnv_cmplt_i,
   input  logic [RES_W-1:0]   a2d_res_i
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic               chnl_q, chnl_d;
   logic [RES_W-1:0]   res_q, res_d;
   logic [NUM_REQ-1:0] pickOh;
   logic [IDX_W-1:0]   pickIdx;
   logic [NUM_REQ-1:0] ownerOh;
   logic               tmoHit;

   rr_priority_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req_i  (req_i),
      .ptr_i  (ptr_q),
      .pick_o (pickOh),
      .idx_o  (pickIdx)
   );

   assign ownerOh = NUM_REQ'(1) << owner_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         chnl_q  <= CHNL_PTAT;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         chnl_q  <= chnl_d;
         res_q   <= res_d;
      end
   end

   // A finished owner moves the pointer past itself so any other pending requester wins next.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      chnl_d  = chnl_q;
      res_d   = res_q;
      case (state_q)
         IDLE: begin
            if (|pickOh) begin
               owner_d = pickIdx;
               chnl_d  = req_chnl_i[pickIdx];
               state_d = START;
            end
         end
         START: state_d = CONV;
         CONV: begin
            if (cnv_cmplt_i) begin
               res_d   = a2d_res_i;
               state_d = DONE;
            end else if (tmoHit) begin
               state_d = DONE;
            end
         end
         DONE: begin
            ptr_d   = (owner_q == IDX_W'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign gnt_o      = (state_q != IDLE) ? ownerOh : '0;
   assign done_o     = (state_q == DONE) ? ownerOh : '0;
   assign busy_o     = (state_q != IDLE);
   assign strt_cnv_o = (state_q == START);
   assign chnl_o     = chnl_q;
   assign res_o      = res_q;

`ifdef A2D_ARB_TMO_EN
   localparam int CNT_W = $clog2(TMO_CYC) + 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tmo_q, tmo_d;

   // The counter's next value reaching TMO_CYC-1 ends the wait, so done lands TMO_CYC cycles after strt_cnv.
   assign tmoHit = (state_q == CONV) && !cnv_cmplt_i && (cnt_q == CNT_W'(TMO_CYC-2));

   always_comb begin
      cnt_d = cnt_q;
      tmo_d = tmo_q;
      if (state_q == START) begin
         cnt_d = '0;
         tmo_d = 1'b0;
      end else if (state_q == CONV) begin
         cnt_d = cnt_q + 1'b1;
         if (tmoHit) begin
            tmo_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         tmo_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tmo_q <= tmo_d;
      end
   end

   assign err_o = (state_q == DONE && tmo_q) ? ownerOh : '0;
`else
   assign tmoHit = 1'b0;
   assign err_o  = '0;
`endif

endmodule

// File: tb/tb_a2d_chnl_arbiter.sv
// Scoreboard bench for a2d_chnl_arbiter: stimulus pushes expected done events, a negedge monitor pops and checks them.
// Timeout scenario follows A2D_ARB_TMO_EN the same way the DUT does.
module tb_a2d_chnl_arbiter;

   typedef struct {
      int          idx;
      logic [11:0] res;
      logic        err;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [1:0]  req;
   logic [1:0]  reqChnl;
   logic [1:0]  gnt;
   logic [1:0]  done;
   logic [1:0]  err;
   logic [11:0] res;
   logic        busy;
   logic        strtCnv;
   logic        chnl;
   logic        cnvCmplt;
   logic [11:0] a2dRes;

   exp_t        expQ[$];
   int          checkCount = 0;
   int          failCount  = 0;
   logic [11:0] lastRes    = '0;

   a2d_chnl_arbiter #(
      .NUM_REQ (2),
      .RES_W   (12),
      .TMO_CYC (16)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_i       (req),
      .req_chnl_i  (reqChnl),
      .gnt_o       (gnt),
      .done_o      (done),
      .err_o       (err),
      .res_o       (res),
      .busy_o      (busy),
      .strt_cnv_o  (strtCnv),
      .chnl_o      (chnl),
      .cnv_cmplt_i (cnvCmplt),
      .a2d_res_i   (a2dRes)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic rstV, input logic [1:0] reqV, input logic [1:0] chnlV,
                                input logic cmpltV, input logic [11:0] resV);
      rst      = rstV;
      req      = reqV;
      reqChnl  = chnlV;
      cnvCmplt = cmpltV;
      a2dRes   = resV;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Precondition: IDLE cycle with the request already applied. Returns in the following IDLE cycle.
   task automatic doConversion(input int expIdx, input logic [11:0] resV, input int waitCyc,
                               input logic chnlExp, input logic [1:0] reqNext);
      exp_t e;
      tick();
      checkOutput("startGnt", gnt, 32'(1) << expIdx);
      checkOutput("startStrt", strtCnv, 1);
      checkOutput("startChnl", chnl, chnlExp);
      tick();
      checkOutput("convStrtLow", strtCnv, 0);
      repeat (waitCyc) tick();
      cnvCmplt = 1'b1;
      a2dRes   = resV;
      e.idx = expIdx; e.res = resV; e.err = 1'b0;
      expQ.push_back(e);
      tick();
      cnvCmplt = 1'b0;
      req      = reqNext;
      tick();
      checkOutput("doneSeen", expQ.size(), 0);
      checkOutput("idleBusy", busy, 0);
      checkOutput("resHeld", res, resV);
      lastRes = resV;
   endtask

   // Precondition: IDLE cycle with request applied. Resets the DUT in the middle of CONV.
   task automatic abortByReset(input int expIdx);
      tick();
      checkOutput("abortStartGnt", gnt, 32'(1) << expIdx);
      tick();
      tick();
      rst = 1'b1;
      tick();
      checkOutput("abortOutputs", {gnt, done, err, res, busy, strtCnv, chnl}, 0);
      rst = 1'b0;
      lastRes = '0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         checkOutput("invariants", {30'd0, $onehot0(gnt), ($onehot0(done) && ((err & ~done) == 2'b00))}, 32'h3);
         if (done != 2'b00) begin
            if (expQ.size() == 0) begin
               checkCount++;
               failCount++;
               $display("[TB] FAIL unexpectedDone: got done=%b, expected no done", done);
            end else begin
               e = expQ.pop_front();
               checkOutput("doneOwner", done, 32'(1) << e.idx);
               checkOutput("doneGnt", gnt, 32'(1) << e.idx);
               checkOutput("doneRes", res, e.res);
               checkOutput("doneErr", err, e.err ? (32'(1) << e.idx) : 0);
            end
         end
      end
   end

   initial begin
      exp_t e;
      applyStimulus(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)));

      // Reset with random inputs
      tick();
      checkOutput("resetOutputs1", {gnt, done, err, res, busy, strtCnv, chnl}, 0);
      applyStimulus(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)));
      tick();
      checkOutput("resetOutputs2", {gnt, done, err, res, busy, strtCnv, chnl}, 0);
      applyStimulus(1'b0, 2'b00, 2'b00, 1'b0, 12'h000);
      tick();
      checkOutput("idleNoReq", busy, 0);

      // Single request on the pressure channel
      applyStimulus(1'b0, 2'b01, 2'b01, 1'b0, 12'h000);
      doConversion(0, 12'hA5C, 9, 1'b1, 2'b00);

      // Contention held from reset
      applyStimulus(1'b1, 2'b11, 2'b10, 1'b0, 12'h000);
      tick();
      rst = 1'b0;
      doConversion(0, 12'h123, 2, 1'b0, 2'b11);
      doConversion(1, 12'h456, 0, 1'b1, 2'b11);
      doConversion(0, 12'h789, 1, 1'b0, 2'b11);
      doConversion(1, 12'hABC, 3, 1'b1, 2'b00);

      // Spurious completes in IDLE and START
      applyStimulus(1'b0, 2'b00, 2'b00, 1'b1, 12'hFFF);
      tick();
      checkOutput("spurIdleBusy", busy, 0);
      req = 2'b01;
      tick();
      checkOutput("spurStartStrt", strtCnv, 1);
      tick();
      cnvCmplt = 1'b0;
      checkOutput("spurConvBusy", busy, 1);
      repeat (3) tick();
      checkOutput("spurStillConv", busy, 1);
      cnvCmplt = 1'b1;
      a2dRes   = 12'h3C7;
      e.idx = 0; e.res = 12'h3C7; e.err = 1'b0;
      expQ.push_back(e);
      tick();
      cnvCmplt = 1'b0;
      req      = 2'b00;
      tick();
      checkOutput("spurDoneSeen", expQ.size(), 0);
      checkOutput("spurRes", res, 12'h3C7);

      // Reset mid-CONV: pointer was 1, after reset requester 0 wins again
      applyStimulus(1'b0, 2'b10, 2'b10, 1'b0, 12'h000);
      abortByReset(1);
      req = 2'b11;
      doConversion(0, 12'h0F0, 2, 1'b0, 2'b10);
      abortByReset(1);
      req = 2'b10;
      doConversion(1, 12'h5A5, 2, 1'b1, 2'b00);

      // Conversion that never completes
      applyStimulus(1'b0, 2'b01, 2'b00, 1'b0, 12'h000);
      tick();
      checkOutput("tmoStartGnt", gnt, 2'b01);
`ifdef A2D_ARB_TMO_EN
      e.idx = 0; e.res = lastRes; e.err = 1'b1;
      expQ.push_back(e);
      repeat (15) tick();
      checkOutput("tmoNotYet", done, 0);
      tick();
      req = 2'b00;
      tick();
      checkOutput("tmoDoneSeen", expQ.size(), 0);
      checkOutput("tmoIdle", busy, 0);
      checkOutput("tmoResKept", res, lastRes);
`else
      repeat (40) tick();
      checkOutput("noTmoBusy", busy, 1);
      checkOutput("noTmoErr", err, 0);
      checkOutput("noTmoRes", res, lastRes);
`endif

      checkOutput("queueEmpty", expQ.size(), 0);
      $display("[TB] End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
